// File: rtl/paralelo_serial_tx.sv
// Serial link transmitter: buffers parallel words in a small FIFO and shifts them out MSB-first,
// filling idle time with comma characters and sending a fixed comma preamble after reset.
module paralelo_serial_tx #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned N_COMMA    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       byte_start,
  output logic       is_data,
  output logic       active_out
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned NCW = $clog2(N_COMMA + 1);

  typedef enum logic [1:0] {ST_RST, ST_SYNC, ST_RUN} state_e;

  state_e         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [NCW-1:0] comma_cnt_q, comma_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           byte_start_q, byte_start_d;
  logic           is_data_q, is_data_d;
  logic           active_q, active_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [7:0]     mem_q [FIFO_DEPTH];

  logic full_c, push_c, pop_c, load_run_c;

  assign full_c     = (count_q == CW'(FIFO_DEPTH));
  assign push_c     = valid_in && !full_c;
  assign ready_out  = !full_c;
  assign data_out   = shift_q[7];
  assign byte_start = byte_start_q;
  assign is_data    = is_data_q;
  assign active_out = active_q;

  // State register and datapath registers
  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state_q      <= ST_RST;
      bit_cnt_q    <= 3'd0;
      comma_cnt_q  <= NCW'(0);
      shift_q      <= 8'h00;
      byte_start_q <= 1'b0;
      is_data_q    <= 1'b0;
      active_q     <= 1'b0;
      wr_ptr_q     <= AW'(0);
      rd_ptr_q     <= AW'(0);
      count_q      <= CW'(0);
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      comma_cnt_q  <= comma_cnt_d;
      shift_q      <= shift_d;
      byte_start_q <= byte_start_d;
      is_data_q    <= is_data_d;
      active_q     <= active_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk_32f) begin
    if (push_c) mem_q[wr_ptr_q] <= data_in;
  end

  // Next-state, byte loading and FIFO bookkeeping
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q + 3'd1;
    comma_cnt_d  = comma_cnt_q;
    shift_d      = {shift_q[6:0], 1'b0};
    byte_start_d = 1'b0;
    is_data_d    = is_data_q;
    active_d     = active_q;
    pop_c        = 1'b0;
    load_run_c   = 1'b0;

    case (state_q)
      ST_RST: begin
        shift_d      = COMMA;
        bit_cnt_d    = 3'd0;
        byte_start_d = 1'b1;
        is_data_d    = 1'b0;
        comma_cnt_d  = NCW'(1);
        state_d      = (N_COMMA == 1) ? ST_RUN : ST_SYNC;
      end
      ST_SYNC: begin
        if (bit_cnt_q == 3'd7) begin
          if (comma_cnt_q == NCW'(N_COMMA)) begin
            state_d    = ST_RUN;
            load_run_c = 1'b1;
          end else begin
            shift_d      = COMMA;
            bit_cnt_d    = 3'd0;
            byte_start_d = 1'b1;
            is_data_d    = 1'b0;
            comma_cnt_d  = comma_cnt_q + NCW'(1);
          end
        end
      end
      ST_RUN: begin
        if (bit_cnt_q == 3'd7) load_run_c = 1'b1;
      end
      default: state_d = ST_RST;
    endcase

    // A RUN boundary sends the FIFO head if one was queued before this edge, else a comma
    if (load_run_c) begin
      bit_cnt_d    = 3'd0;
      byte_start_d = 1'b1;
      active_d     = 1'b1;
      if (count_q != CW'(0)) begin
        shift_d   = mem_q[rd_ptr_q];
        is_data_d = 1'b1;
        pop_c     = 1'b1;
      end else begin
        shift_d   = COMMA;
        is_data_d = 1'b0;
      end
    end

    wr_ptr_d = wr_ptr_q + AW'(push_c);
    rd_ptr_d = rd_ptr_q + AW'(pop_c);
    count_d  = count_q + CW'(push_c) - CW'(pop_c);
  end

endmodule
